// File: rtl/cache_ctrl_fsm.sv
// Cache controller FSM: CPU request sequencing, hit/miss handling, and multi-word
// memory bursts for eviction and refill under write-through or write-back policy.
module cache_ctrl_fsm #(
  parameter int WORDS_PER_LINE = 4,
  parameter bit WRITE_BACK     = 1'b0,
  localparam int CW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Strobe,
  input  logic          RW,
  input  logic          M,
  input  logic          V,
  input  logic          D,
  input  logic          MAck,
  output logic          Rdy,
  output logic          Busy,
  output logic          W,
  output logic          WSel,
  output logic          LdTag,
  output logic          SetDirty,
  output logic          MStrobe,
  output logic          MRW,
  output logic [CW-1:0] WordIdx
);

  // state  | meaning
  // IDLE   | waiting for Strobe
  // LOOKUP | tag compare, hit/miss decision
  // WRMEM  | single-word write to memory (write-through)
  // EVICT  | burst write-back of a dirty line
  // REFILL | burst read of the line from memory
  // DONE   | one-cycle Rdy pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRMEM,
    S_EVICT,
    S_REFILL,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WORDS_PER_LINE - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_ctr;
  logic [CW-1:0] w_ctr_next;
  logic          r_rw;
  logic          w_take;
  logic          w_hit;
  logic          w_dirty;
  logic          w_last;

  assign w_hit   = M & V;
  assign w_dirty = WRITE_BACK ? (V & D) : 1'b0;
  assign w_last  = (r_ctr == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ctr   <= '0;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctr   <= w_ctr_next;
      if (w_take) r_rw <= RW;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ctr_next = r_ctr;
    w_take     = 1'b0;
    Rdy        = 1'b0;
    Busy       = 1'b0;
    W          = 1'b0;
    WSel       = 1'b0;
    LdTag      = 1'b0;
    SetDirty   = 1'b0;
    MStrobe    = 1'b0;
    MRW        = 1'b0;
    WordIdx    = '0;
    case (r_state)
      S_IDLE: begin
        if (Strobe) begin
          w_take = 1'b1;
          w_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        Busy = 1'b1;
        if (w_hit) begin
          if (r_rw) begin
            w_next = S_DONE;
          end else begin
            W = 1'b1;
            if (WRITE_BACK) begin
              SetDirty = 1'b1;
              w_next   = S_DONE;
            end else begin
              w_next = S_WRMEM;
            end
          end
        end else if (r_rw || WRITE_BACK) begin
          w_next = w_dirty ? S_EVICT : S_REFILL;
        end else begin
          // write-through miss: no allocate, the word goes straight to memory
          w_next = S_WRMEM;
        end
      end
      S_WRMEM: begin
        Busy    = 1'b1;
        MStrobe = 1'b1;
        if (MAck) w_next = S_DONE;
      end
      S_EVICT: begin
        Busy    = 1'b1;
        MStrobe = 1'b1;
        WordIdx = r_ctr;
        if (MAck) begin
          if (w_last) begin
            w_ctr_next = '0;
            w_next     = S_REFILL;
          end else begin
            w_ctr_next = r_ctr + CW'(1);
          end
        end
      end
      S_REFILL: begin
        Busy    = 1'b1;
        MStrobe = 1'b1;
        MRW     = 1'b1;
        WSel    = 1'b1;
        W       = MAck;
        WordIdx = r_ctr;
        if (MAck) begin
          if (w_last) begin
            // re-lookup after tag load; a write-allocate finishes as a write hit
            LdTag      = 1'b1;
            w_ctr_next = '0;
            w_next     = S_LOOKUP;
          end else begin
            w_ctr_next = r_ctr + CW'(1);
          end
        end
      end
      S_DONE: begin
        Busy   = 1'b1;
        Rdy    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: write-through (4 words), write-back (4 words)
// and write-back single-word instances, checking the full output vector per cycle.
module tb_cache_ctrl_fsm;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // instance A: write-through, 4 words
  logic a_rst_n, a_strobe, a_rw, a_m, a_v, a_d, a_mack;
  logic a_rdy, a_busy, a_w, a_wsel, a_ld, a_sd, a_ms, a_mrw;
  logic [1:0] a_idx;
  // instance B: write-back, 4 words
  logic b_rst_n, b_strobe, b_rw, b_m, b_v, b_d, b_mack;
  logic b_rdy, b_busy, b_w, b_wsel, b_ld, b_sd, b_ms, b_mrw;
  logic [1:0] b_idx;
  // instance C: write-back, 1 word
  logic c_rst_n, c_strobe, c_rw, c_m, c_v, c_d, c_mack;
  logic c_rdy, c_busy, c_w, c_wsel, c_ld, c_sd, c_ms, c_mrw;
  logic [0:0] c_idx;

  cache_ctrl_fsm #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .Strobe(a_strobe), .RW(a_rw), .M(a_m), .V(a_v), .D(a_d),
    .MAck(a_mack), .Rdy(a_rdy), .Busy(a_busy), .W(a_w), .WSel(a_wsel), .LdTag(a_ld),
    .SetDirty(a_sd), .MStrobe(a_ms), .MRW(a_mrw), .WordIdx(a_idx));

  cache_ctrl_fsm #(.WORDS_PER_LINE(4), .WRITE_BACK(1'b1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .Strobe(b_strobe), .RW(b_rw), .M(b_m), .V(b_v), .D(b_d),
    .MAck(b_mack), .Rdy(b_rdy), .Busy(b_busy), .W(b_w), .WSel(b_wsel), .LdTag(b_ld),
    .SetDirty(b_sd), .MStrobe(b_ms), .MRW(b_mrw), .WordIdx(b_idx));

  cache_ctrl_fsm #(.WORDS_PER_LINE(1), .WRITE_BACK(1'b1)) u_c (
    .clk(clk), .rst_n(c_rst_n), .Strobe(c_strobe), .RW(c_rw), .M(c_m), .V(c_v), .D(c_d),
    .MAck(c_mack), .Rdy(c_rdy), .Busy(c_busy), .W(c_w), .WSel(c_wsel), .LdTag(c_ld),
    .SetDirty(c_sd), .MStrobe(c_ms), .MRW(c_mrw), .WordIdx(c_idx));

  logic [9:0] a_out, b_out, c_out;
  assign a_out = {a_rdy, a_busy, a_w, a_wsel, a_ld, a_sd, a_ms, a_mrw, a_idx};
  assign b_out = {b_rdy, b_busy, b_w, b_wsel, b_ld, b_sd, b_ms, b_mrw, b_idx};
  assign c_out = {c_rdy, c_busy, c_w, c_wsel, c_ld, c_sd, c_ms, c_mrw, 1'b0, c_idx};

  // expected vector: {Rdy, Busy, W, WSel, LdTag, SetDirty, MStrobe, MRW, WordIdx}
  function automatic logic [9:0] o(input logic rdy, input logic busy, input logic w,
                                   input logic wsel, input logic ld, input logic sd,
                                   input logic ms, input logic mrw, input logic [1:0] idx);
    return {rdy, busy, w, wsel, ld, sd, ms, mrw, idx};
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_rst_n, a_strobe, a_rw, a_m, a_v, a_d, a_mack} = '0;
    {b_rst_n, b_strobe, b_rw, b_m, b_v, b_d, b_mack} = '0;
    {c_rst_n, c_strobe, c_rw, c_m, c_v, c_d, c_mack} = '0;
    a_strobe = 1'b1;  // reset must win over a simultaneous request
    tick();
    tick();
    #1;
    chk("reset_a", a_out, 10'b0);
    chk("reset_b", b_out, 10'b0);
    chk("reset_c", c_out, 10'b0);
    a_strobe = 1'b0;
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    tick();
    #1 chk("idle_after_reset_a", a_out, 10'b0);

    // read hit, write-through: Rdy two cycles after Strobe
    a_strobe = 1'b1; a_rw = 1'b1; a_m = 1'b1; a_v = 1'b1;
    tick();
    a_strobe = 1'b0;
    #1 chk("rdhit_lookup", a_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("rdhit_done", a_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("rdhit_idle", a_out, 10'b0);

    // clean read miss, write-through, MAck alternate, Strobe held throughout
    a_strobe = 1'b1; a_rw = 1'b1; a_m = 1'b0; a_v = 1'b0; a_mack = 1'b0;
    tick();
    #1 chk("rmiss_lookup", a_out, o(0,1,0,0,0,0,0,0,2'd0));
    for (int k = 0; k < 4; k++) begin
      tick();
      a_mack = 1'b0;
      #1 chk($sformatf("rmiss_wait%0d", k), a_out, o(0,1,0,1,0,0,1,1,2'(k)));
      tick();
      a_mack = 1'b1;
      #1 chk($sformatf("rmiss_beat%0d", k), a_out, o(0,1,1,1,(k == 3),0,1,1,2'(k)));
    end
    tick();
    a_mack = 1'b0; a_m = 1'b1; a_v = 1'b1;
    #1 chk("rmiss_relookup", a_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    a_strobe = 1'b0;
    #1 chk("rmiss_done_c11", a_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("rmiss_idle", a_out, 10'b0);
    tick();
    #1 chk("rmiss_not_queued", a_out, 10'b0);

    // write-through write hit: W in LOOKUP, WRMEM waits one cycle for MAck
    a_strobe = 1'b1; a_rw = 1'b0; a_m = 1'b1; a_v = 1'b1;
    tick();
    a_strobe = 1'b0; a_rw = 1'b1;
    #1 chk("wt_whit_lookup", a_out, o(0,1,1,0,0,0,0,0,2'd0));
    tick();
    #1 chk("wt_whit_wrmem_wait", a_out, o(0,1,0,0,0,0,1,0,2'd0));
    tick();
    a_mack = 1'b1;
    #1 chk("wt_whit_wrmem_ack", a_out, o(0,1,0,0,0,0,1,0,2'd0));
    tick();
    a_mack = 1'b0;
    #1 chk("wt_whit_done", a_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("wt_whit_idle", a_out, 10'b0);

    // write-through write miss with a dirty line: still no allocate
    a_strobe = 1'b1; a_rw = 1'b0; a_m = 1'b0; a_v = 1'b1; a_d = 1'b1;
    tick();
    a_strobe = 1'b0;
    #1 chk("wt_wmiss_lookup", a_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    a_mack = 1'b1;
    #1 chk("wt_wmiss_wrmem", a_out, o(0,1,0,0,0,0,1,0,2'd0));
    tick();
    a_mack = 1'b0;
    #1 chk("wt_wmiss_done", a_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("wt_wmiss_idle", a_out, 10'b0);

    // write-back write hit: W and SetDirty, Rdy next cycle, no memory traffic
    b_strobe = 1'b1; b_rw = 1'b0; b_m = 1'b1; b_v = 1'b1;
    tick();
    b_strobe = 1'b0;
    #1 chk("wb_whit_lookup", b_out, o(0,1,1,0,0,1,0,0,2'd0));
    tick();
    #1 chk("wb_whit_done", b_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("wb_whit_idle", b_out, 10'b0);

    // dirty read miss, write-back, MAck held high (also high while idle)
    b_strobe = 1'b1; b_rw = 1'b1; b_m = 1'b0; b_v = 1'b1; b_d = 1'b1; b_mack = 1'b1;
    tick();
    b_strobe = 1'b0;
    #1 chk("dmiss_lookup", b_out, o(0,1,0,0,0,0,0,0,2'd0));
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 chk($sformatf("dmiss_evict%0d", k), b_out, o(0,1,0,0,0,0,1,0,2'(k)));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 chk($sformatf("dmiss_refill%0d", k), b_out, o(0,1,1,1,(k == 3),0,1,1,2'(k)));
    end
    tick();
    b_mack = 1'b0; b_m = 1'b1; b_d = 1'b0;
    #1 chk("dmiss_relookup", b_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("dmiss_done_c11", b_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("dmiss_idle", b_out, 10'b0);

    // write-back clean write miss: allocate, then finish through write-hit path
    b_strobe = 1'b1; b_rw = 1'b0; b_m = 1'b0; b_v = 1'b0; b_d = 1'b0; b_mack = 1'b1;
    tick();
    b_strobe = 1'b0;
    #1 chk("walloc_lookup", b_out, o(0,1,0,0,0,0,0,0,2'd0));
    for (int k = 0; k < 4; k++) begin
      tick();
      #1 chk($sformatf("walloc_refill%0d", k), b_out, o(0,1,1,1,(k == 3),0,1,1,2'(k)));
    end
    tick();
    b_mack = 1'b0; b_m = 1'b1; b_v = 1'b1;
    #1 chk("walloc_relookup", b_out, o(0,1,1,0,0,1,0,0,2'd0));
    tick();
    #1 chk("walloc_done", b_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("walloc_idle", b_out, 10'b0);

    // reset at refill beat 2 aborts; a new request restarts at word 0
    b_strobe = 1'b1; b_rw = 1'b1; b_m = 1'b0; b_v = 1'b0; b_mack = 1'b1;
    tick();
    b_strobe = 1'b0;
    tick();
    #1 chk("abort_beat0", b_out, o(0,1,1,1,0,0,1,1,2'd0));
    tick();
    tick();
    b_rst_n = 1'b0;
    #1 chk("abort_beat2", b_out, o(0,1,1,1,0,0,1,1,2'd2));
    tick();
    b_strobe = 1'b1;
    #1 chk("abort_idle", b_out, 10'b0);
    tick();
    #1 chk("abort_reset_wins", b_out, 10'b0);
    b_rst_n = 1'b1; b_mack = 1'b0;
    tick();
    b_strobe = 1'b0;
    #1 chk("restart_lookup", b_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("restart_idx0", b_out, o(0,1,0,1,0,0,1,1,2'd0));
    b_mack = 1'b1;
    #1 chk("restart_beat0", b_out, o(0,1,1,1,0,0,1,1,2'd0));
    tick();
    #1 chk("restart_beat1", b_out, o(0,1,1,1,0,0,1,1,2'd1));

    // single-word line, write-back, dirty read miss
    c_strobe = 1'b1; c_rw = 1'b1; c_m = 1'b0; c_v = 1'b1; c_d = 1'b1; c_mack = 1'b0;
    tick();
    c_strobe = 1'b0;
    #1 chk("w1_lookup", c_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("w1_evict_wait", c_out, o(0,1,0,0,0,0,1,0,2'd0));
    tick();
    c_mack = 1'b1;
    #1 chk("w1_evict_ack", c_out, o(0,1,0,0,0,0,1,0,2'd0));
    tick();
    #1 chk("w1_refill_last", c_out, o(0,1,1,1,1,0,1,1,2'd0));
    tick();
    c_mack = 1'b0; c_m = 1'b1; c_d = 1'b0;
    #1 chk("w1_relookup", c_out, o(0,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("w1_done", c_out, o(1,1,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("w1_idle", c_out, 10'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
